// File: rtl/dmux_stream_1xn_pkg.sv
// Shared definitions for the 1xN stream demultiplexer: channel limit,
// routing kinds and the select-width helpers.
package dmux_pkg;

  localparam int DMUX_MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    ROUTE_UNICAST = 2'd0,
    ROUTE_BCAST   = 2'd1,
    ROUTE_DROP    = 2'd2
  } route_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int sel_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/dmux_stream_1xn_if.sv
// Stream bundle between one producer and CHANNELS consumers. The master
// modport is the producer/consumer side, the slave modport is the demux.
interface dmux_stream_1xn_if
  import dmux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dmux_stream_1xn_out_slot.sv
// One-entry output register for a single channel. A load and a drain in the
// same cycle keep the slot full with the new word, so each channel sustains
// one word per cycle.
module dmux_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_out_ready,
  output logic             o_can_take,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Valid bit: set by a load, cleared when the held word drains with no reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Data register only changes on a load, so a stalled word stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end
  end

  assign o_can_take  = !r_valid || i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

endmodule

// File: rtl/dmux_stream_1xn.sv
// 1xN stream demultiplexer: unicast or atomic broadcast into per-channel
// output slots, with out-of-range selects sunk and counted as drops.
module dmux_stream_1xn
  import dmux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmux_stream_1xn_if.slave      bus,
  input  logic                  err_clr,
  output logic                  err_sel,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int SEL_W = sel_width(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > DMUX_MAX_CHANNELS) begin : g_badChannels
    $error("dmux_stream_1xn: CHANNELS out of supported range");
  end

  route_e                    w_route;
  logic [CHANNELS-1:0]       w_canTake;
  logic [CHANNELS-1:0]       w_selHit;
  logic [CHANNELS-1:0]       w_load;
  logic [CHANNELS-1:0]       w_outValid;
  logic [CHANNELS*WIDTH-1:0] w_outData;
  logic                      w_inRange;
  logic                      w_inReady;
  logic                      w_accept;
  logic                      w_drop;
  logic                      r_errSel;
  logic [CNT_W-1:0]          r_dropCnt;

  // Classify the offered word, decide readiness and pick the target slots.
  // Broadcast waits for every slot so that it lands everywhere at once.
  always_comb begin
    w_selHit  = '0;
    w_load    = '0;
    w_inReady = 1'b1;
    w_drop    = 1'b0;
    w_inRange = (int'(bus.in_sel) < CHANNELS);
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        w_selHit[k] = 1'b1;
      end
    end
    if (bus.in_bcast) begin
      w_route = ROUTE_BCAST;
    end else if (w_inRange) begin
      w_route = ROUTE_UNICAST;
    end else begin
      w_route = ROUTE_DROP;
    end
    case (w_route)
      ROUTE_BCAST:   w_inReady = &w_canTake;
      ROUTE_UNICAST: w_inReady = |(w_selHit & w_canTake);
      default:       w_inReady = 1'b1;
    endcase
    w_accept = bus.in_valid && w_inReady;
    if (w_accept) begin
      case (w_route)
        ROUTE_BCAST:   w_load = '1;
        ROUTE_UNICAST: w_load = w_selHit;
        default:       w_drop = 1'b1;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    dmux_out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load[k]),
      .i_load_data (bus.in_data),
      .i_out_ready (bus.out_ready[k]),
      .o_can_take  (w_canTake[k]),
      .o_out_valid (w_outValid[k]),
      .o_out_data  (w_outData[k*WIDTH +: WIDTH])
    );
  end

  // Sticky select error and saturating drop counter; a drop in the same
  // cycle as a clear restarts the count at one rather than losing the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errSel  <= 1'b0;
      r_dropCnt <= '0;
    end else if (w_drop && err_clr) begin
      r_errSel  <= 1'b1;
      r_dropCnt <= CNT_W'(1);
    end else if (err_clr) begin
      r_errSel  <= 1'b0;
      r_dropCnt <= '0;
    end else if (w_drop) begin
      r_errSel <= 1'b1;
      if (r_dropCnt != {CNT_W{1'b1}}) begin
        r_dropCnt <= r_dropCnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = w_outData;
  assign err_sel       = r_errSel;
  assign drop_cnt      = r_dropCnt;

endmodule

// File: tb/tb_dmux_stream_1xn.sv
// Directed bench for dmux_stream_1xn: a 4-channel instance for routing,
// backpressure and broadcast, and two 3-channel instances (8-bit and 2-bit
// drop counters) for out-of-range selects.
module tb_dmux_stream_1xn;
  import dmux_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       errClr = 1'b0;
  logic       errSel4, errSel3, errSel3s;
  logic [7:0] dropCnt4, dropCnt3;
  logic [1:0] dropCnt3s;
  int         nVectors = 0;
  int         nMiscompares = 0;

  always #5 clk = ~clk;

  dmux_stream_1xn_if #(.WIDTH(4), .CHANNELS(4)) bus4 ();
  dmux_stream_1xn_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();
  dmux_stream_1xn_if #(.WIDTH(4), .CHANNELS(3)) bus3s ();

  dmux_stream_1xn #(.WIDTH(4), .CHANNELS(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .err_clr(errClr), .err_sel(errSel4), .drop_cnt(dropCnt4)
  );

  dmux_stream_1xn #(.WIDTH(4), .CHANNELS(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
    .err_clr(errClr), .err_sel(errSel3), .drop_cnt(dropCnt3)
  );

  dmux_stream_1xn #(.WIDTH(4), .CHANNELS(3), .CNT_W(2)) u_dut3s (
    .clk(clk), .rst_n(rst_n), .bus(bus3s.slave),
    .err_clr(errClr), .err_sel(errSel3s), .drop_cnt(dropCnt3s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] sel,
                               input logic [3:0] data, input logic bcast,
                               input logic [3:0] ready);
    bus4.in_valid  = valid;
    bus4.in_sel    = sel;
    bus4.in_data   = data;
    bus4.in_bcast  = bcast;
    bus4.out_ready = ready;
  endtask

  task automatic applyStimulus3(input logic valid, input logic [1:0] sel,
                                input logic [3:0] data);
    bus3.in_valid   = valid;
    bus3.in_sel     = sel;
    bus3.in_data    = data;
    bus3.in_bcast   = 1'b0;
    bus3.out_ready  = 3'b111;
    bus3s.in_valid  = valid;
    bus3s.in_sel    = sel;
    bus3s.in_data   = data;
    bus3s.in_bcast  = 1'b0;
    bus3s.out_ready = 3'b111;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    applyStimulus3(1'b0, 2'd0, 4'h0);
    #2;
    nVectors++;
    if (bus4.out_valid !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL reset_valid: got %b want 0000", bus4.out_valid);
    end
    nVectors++;
    if (bus4.out_data !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL reset_data: got %h want 0000", bus4.out_data);
    end
    nVectors++;
    if (bus4.in_ready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL reset_ready: got %b want 1", bus4.in_ready);
    end
    nVectors++;
    if (errSel4 !== 1'b0 || dropCnt4 !== 8'd0 || errSel3 !== 1'b0 || dropCnt3 !== 8'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_err: got err4=%b cnt4=%0d err3=%b cnt3=%0d want 0", errSel4, dropCnt4, errSel3, dropCnt3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unicast_sweep();
    logic [1:0] prevSel;
    logic [3:0] prevData;
    logic [3:0] expValid;
    prevSel  = 2'd0;
    prevData = 4'h0;
    tick();
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin
        expValid = 4'b0001 << prevSel;
        nVectors++;
        if (bus4.out_valid !== expValid) begin
          nMiscompares++;
          $display("[TB] FAIL uni_valid word=%0d: got %b want %b", i - 1, bus4.out_valid, expValid);
        end
        nVectors++;
        if (bus4.out_data[int'(prevSel)*4 +: 4] !== prevData) begin
          nMiscompares++;
          $display("[TB] FAIL uni_data word=%0d: got %h want %h", i - 1, bus4.out_data[int'(prevSel)*4 +: 4], prevData);
        end
      end
      applyStimulus(1'b1, 2'(i / 16), 4'(i % 16), 1'b0, 4'hF);
      #1;
      nVectors++;
      if (bus4.in_ready !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL uni_ready word=%0d: got %b want 1", i, bus4.in_ready);
      end
      prevSel  = 2'(i / 16);
      prevData = 4'(i % 16);
      tick();
    end
    nVectors++;
    if (bus4.out_valid !== 4'b1000 || bus4.out_data[15:12] !== prevData) begin
      nMiscompares++;
      $display("[TB] FAIL uni_last: got v=%b d=%h want v=1000 d=%h", bus4.out_valid, bus4.out_data[15:12], prevData);
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL uni_drain: got %b want 0000", bus4.out_valid);
    end
    nVectors++;
    if (dropCnt4 !== 8'd0 || errSel4 !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL uni_nodrop: got cnt=%0d err=%b want 0 0", dropCnt4, errSel4);
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 2'd2, 4'hA, 1'b0, 4'b1011);
    #1;
    nVectors++;
    if (bus4.in_ready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL bp_first_ready: got %b want 1", bus4.in_ready);
    end
    tick();
    applyStimulus(1'b1, 2'd2, 4'h5, 1'b0, 4'b1011);
    #1;
    nVectors++;
    if (bus4.in_ready !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL bp_second_ready: got %b want 0", bus4.in_ready);
    end
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0100 || bus4.out_data[11:8] !== 4'hA) begin
      nMiscompares++;
      $display("[TB] FAIL bp_hold: got v=%b d=%h want v=0100 d=a", bus4.out_valid, bus4.out_data[11:8]);
    end
    applyStimulus(1'b1, 2'd2, 4'h5, 1'b0, 4'hF);
    #1;
    nVectors++;
    if (bus4.in_ready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL bp_release_ready: got %b want 1", bus4.in_ready);
    end
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0100 || bus4.out_data[11:8] !== 4'h5) begin
      nMiscompares++;
      $display("[TB] FAIL bp_second_word: got v=%b d=%h want v=0100 d=5", bus4.out_valid, bus4.out_data[11:8]);
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL bp_drain: got %b want 0000", bus4.out_valid);
    end
  endtask

  task automatic test_independence();
    logic [3:0] word;
    applyStimulus(1'b1, 2'd1, 4'h3, 1'b0, 4'b1101);
    tick();
    for (int i = 0; i < 8; i++) begin
      word = 4'(i + 8);
      applyStimulus(1'b1, 2'd0, word, 1'b0, 4'b1101);
      #1;
      nVectors++;
      if (bus4.in_ready !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL ind_ready i=%0d: got %b want 1", i, bus4.in_ready);
      end
      tick();
      nVectors++;
      if (bus4.out_valid !== 4'b0011 || bus4.out_data[3:0] !== word || bus4.out_data[7:4] !== 4'h3) begin
        nMiscompares++;
        $display("[TB] FAIL ind_out i=%0d: got v=%b d0=%h d1=%h want v=0011 d0=%h d1=3", i, bus4.out_valid, bus4.out_data[3:0], bus4.out_data[7:4], word);
      end
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL ind_drain: got %b want 0000", bus4.out_valid);
    end
  endtask

  task automatic test_broadcast();
    applyStimulus(1'b1, 2'd2, 4'h9, 1'b0, 4'b1011);
    tick();
    applyStimulus(1'b1, 2'd0, 4'hC, 1'b1, 4'b1011);
    #1;
    nVectors++;
    if (bus4.in_ready !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL bc_blocked_ready: got %b want 0", bus4.in_ready);
    end
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0100 || bus4.out_data[11:8] !== 4'h9 || bus4.in_ready !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL bc_no_partial: got v=%b d2=%h rdy=%b want v=0100 d2=9 rdy=0", bus4.out_valid, bus4.out_data[11:8], bus4.in_ready);
    end
    applyStimulus(1'b1, 2'd0, 4'hC, 1'b1, 4'hF);
    #1;
    nVectors++;
    if (bus4.in_ready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL bc_ready: got %b want 1", bus4.in_ready);
    end
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b1111 || bus4.out_data !== 16'hCCCC) begin
      nMiscompares++;
      $display("[TB] FAIL bc_all: got v=%b d=%h want v=1111 d=cccc", bus4.out_valid, bus4.out_data);
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL bc_drain: got %b want 0000", bus4.out_valid);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] expCnt;
    logic [1:0] expSat;
    for (int i = 0; i < 6; i++) begin
      applyStimulus3(1'b1, 2'd3, 4'h7);
      #1;
      nVectors++;
      if (bus3.in_ready !== 1'b1 || bus3s.in_ready !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL oor_ready i=%0d: got %b/%b want 1/1", i, bus3.in_ready, bus3s.in_ready);
      end
      tick();
      expCnt = 8'(i + 1);
      expSat = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
      nVectors++;
      if (bus3.out_valid !== 3'b000 || bus3s.out_valid !== 3'b000) begin
        nMiscompares++;
        $display("[TB] FAIL oor_novalid i=%0d: got %b/%b want 000", i, bus3.out_valid, bus3s.out_valid);
      end
      nVectors++;
      if (errSel3 !== 1'b1 || dropCnt3 !== expCnt || dropCnt3s !== expSat) begin
        nMiscompares++;
        $display("[TB] FAIL oor_count i=%0d: got err=%b cnt=%0d sat=%0d want 1 %0d %0d", i, errSel3, dropCnt3, dropCnt3s, expCnt, expSat);
      end
    end
    applyStimulus3(1'b0, 2'd0, 4'h0);
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    nVectors++;
    if (errSel3 !== 1'b0 || dropCnt3 !== 8'd0 || errSel3s !== 1'b0 || dropCnt3s !== 2'd0) begin
      nMiscompares++;
      $display("[TB] FAIL oor_clear: got err=%b cnt=%0d errs=%b sat=%0d want 0 0 0 0", errSel3, dropCnt3, errSel3s, dropCnt3s);
    end
    applyStimulus3(1'b1, 2'd3, 4'h7);
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    applyStimulus3(1'b1, 2'd2, 4'h4);
    nVectors++;
    if (errSel3 !== 1'b1 || dropCnt3 !== 8'd1 || dropCnt3s !== 2'd1) begin
      nMiscompares++;
      $display("[TB] FAIL oor_clear_vs_drop: got err=%b cnt=%0d sat=%0d want 1 1 1", errSel3, dropCnt3, dropCnt3s);
    end
    tick();
    nVectors++;
    if (bus3.out_valid !== 3'b100 || bus3.out_data[11:8] !== 4'h4 || dropCnt3 !== 8'd1) begin
      nMiscompares++;
      $display("[TB] FAIL oor_inrange: got v=%b d2=%h cnt=%0d want v=100 d2=4 cnt=1", bus3.out_valid, bus3.out_data[11:8], dropCnt3);
    end
    applyStimulus3(1'b0, 2'd0, 4'h0);
    tick();
    nVectors++;
    if (errSel4 !== 1'b0 || dropCnt4 !== 8'd0) begin
      nMiscompares++;
      $display("[TB] FAIL pow2_noerr: got err=%b cnt=%0d want 0 0", errSel4, dropCnt4);
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, 2'd0, 4'h6, 1'b0, 4'b0110);
    applyStimulus3(1'b1, 2'd3, 4'h7);
    tick();
    applyStimulus(1'b1, 2'd3, 4'hE, 1'b0, 4'b0110);
    applyStimulus3(1'b0, 2'd0, 4'h0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'b0110);
    nVectors++;
    if (bus4.out_valid !== 4'b1001 || bus4.out_data[3:0] !== 4'h6 || bus4.out_data[15:12] !== 4'hE || errSel3 !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL mid_preload: got v=%b d0=%h d3=%h err3=%b want v=1001 d0=6 d3=e err3=1", bus4.out_valid, bus4.out_data[3:0], bus4.out_data[15:12], errSel3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nVectors++;
    if (bus4.out_valid !== 4'b0000 || bus4.out_data !== 16'h0000) begin
      nMiscompares++;
      $display("[TB] FAIL mid_reset_out: got v=%b d=%h want 0000 0000", bus4.out_valid, bus4.out_data);
    end
    nVectors++;
    if (dropCnt3 !== 8'd0 || errSel3 !== 1'b0 || dropCnt4 !== 8'd0) begin
      nMiscompares++;
      $display("[TB] FAIL mid_reset_err: got cnt3=%0d err3=%b cnt4=%0d want 0 0 0", dropCnt3, errSel3, dropCnt4);
    end
    #2;
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 2'd1, 4'hB, 1'b0, 4'hF);
    #1;
    nVectors++;
    if (bus4.in_ready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL mid_after_ready: got %b want 1", bus4.in_ready);
    end
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    nVectors++;
    if (bus4.out_valid !== 4'b0010 || bus4.out_data[7:4] !== 4'hB) begin
      nMiscompares++;
      $display("[TB] FAIL mid_after_word: got v=%b d1=%h want v=0010 d1=b", bus4.out_valid, bus4.out_data[7:4]);
    end
    tick();
    nVectors++;
    if (bus4.out_valid !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL mid_after_drain: got %b want 0000", bus4.out_valid);
    end
  endtask

  initial begin
    $display("[TB] dmux_stream_1xn directed bench");
    test_reset();
    test_unicast_sweep();
    test_backpressure();
    test_independence();
    test_broadcast();
    test_out_of_range();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
